bicubic_block_packer: RTL and testbench



---
 rtl/bicubic_pkg.sv | 29 ++
 rtl/bicubic_line_ram.sv | 27 ++
 rtl/bicubic_block_packer.sv | 233 +++++++++++++++++++++++
 tb/tb_bicubic_block_packer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bicubic_pkg.sv
// Shared constants, packer state encoding and line-buffer rotation helper
// for the bicubic block packer and its line RAMs.
package bicubic_pkg;

    localparam int unsigned PIX_W     = 24;
    localparam int unsigned CH_W      = 8;
    localparam int unsigned WIN_N     = 4;
    localparam int unsigned WIN_BYTES = WIN_N * WIN_N;
    localparam int unsigned LB_N      = WIN_N - 1;

    // Channel byte offsets inside a {b,g,r} pixel
    localparam int unsigned R_OFF = 0;
    localparam int unsigned G_OFF = 8;
    localparam int unsigned B_OFF = 16;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACTIVE   = 2'd1,
        DROP     = 2'd2
    } packer_state_e;

    typedef logic [1:0] lb_sel_t;

    // Modulo-3 increment of a line-buffer index
    function automatic lb_sel_t lb_next(input lb_sel_t s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

endpackage

// File: rtl/bicubic_line_ram.sv
// Single-port read-first line RAM with registered read data; contents are
// not reset.
module bicubic_line_ram #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 640,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             en_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            rdata_o <= mem_q[addr_i];
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end
        end
    end

endmodule

// File: rtl/bicubic_block_packer.sv
// Raster AXI4-Stream to 4x4 per-channel window packer for the bicubic value buffer.
// Optional frame-error reporting ports: define BICUBIC_PACKER_FRAME_CHECK_EN.
module bicubic_block_packer
    import bicubic_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [PIX_W-1:0]         s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tuser,
    input  logic                     s_axis_tlast,
    input  logic                     i_load_ready,
    output logic [WIN_BYTES*CH_W-1:0] o_pixel_data_r,
    output logic [WIN_BYTES*CH_W-1:0] o_pixel_data_g,
    output logic [WIN_BYTES*CH_W-1:0] o_pixel_data_b,
    output logic                     o_valid,
    output logic                     o_sof,
    output logic                     o_eof
`ifdef BICUBIC_PACKER_FRAME_CHECK_EN
   ,output logic                     o_err_short,
    output logic                     o_err_long,
    output logic [15:0]              o_err_count
`endif
);

    localparam int unsigned XW = $clog2(IMG_WIDTH);
    localparam int unsigned YW = $clog2(IMG_HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
    localparam logic [XW-1:0] X_WIN  = XW'(WIN_N - 1);
    localparam logic [YW-1:0] Y_WIN  = YW'(WIN_N - 1);

    packer_state_e state_q, state_d;
    logic [XW-1:0] x_q, x_d, x_eff;
    logic [YW-1:0] y_q, y_d, y_eff;
    logic          ovf_q, ovf_d;
    lb_sel_t       sel_q, sel_d;
    logic          acc_c, wr_c, emit_c, sof_c, eof_c, short_c, long_c;

    logic                          v1_q, sof1_q, eof1_q, sh1_q;
    logic [PIX_W-1:0]              pix1_q;
    lb_sel_t                       rsel1_q;
    logic [PIX_W-1:0]              lb_rd [LB_N];
    logic [WIN_N-1:0][PIX_W-1:0]   col_c;
    logic [WIN_N-1:0][WIN_N-1:0][PIX_W-1:0] win_q, win_d;

    assign s_axis_tready = i_load_ready & ~i_rst & ((state_q != WAIT_SOF) | s_axis_tuser);
    assign acc_c         = s_axis_tvalid & s_axis_tready;

    // Frame/line tracking: a tuser beat restarts at (0,0) from any state
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        ovf_d   = ovf_q;
        sel_d   = sel_q;
        x_eff   = x_q;
        y_eff   = y_q;
        wr_c    = 1'b0;
        emit_c  = 1'b0;
        sof_c   = 1'b0;
        eof_c   = 1'b0;
        short_c = 1'b0;
        long_c  = 1'b0;
        if (acc_c) begin
            if (s_axis_tuser) begin
                x_eff = '0;
                y_eff = '0;
                wr_c  = 1'b1;
            end else if (state_q == ACTIVE && !ovf_q) begin
                wr_c = 1'b1;
            end
            if (wr_c) begin
                state_d = ACTIVE;
                ovf_d   = 1'b0;
                emit_c  = (x_eff >= X_WIN) && (y_eff >= Y_WIN);
                sof_c   = (x_eff == X_WIN) && (y_eff == Y_WIN);
                eof_c   = (x_eff == X_LAST) && (y_eff == Y_LAST);
                y_d     = y_eff;
                if (x_eff == X_LAST) begin
                    if (s_axis_tlast) begin
                        x_d   = '0;
                        y_d   = y_eff + YW'(1);
                        sel_d = lb_next(sel_q);
                        if (y_eff == Y_LAST) begin
                            state_d = WAIT_SOF;
                            y_d     = '0;
                        end
                    end else begin
                        x_d    = x_eff;
                        ovf_d  = 1'b1;
                        long_c = 1'b1;
                    end
                end else if (s_axis_tlast) begin
                    state_d = DROP;
                    short_c = 1'b1;
                end else begin
                    x_d = x_eff + XW'(1);
                end
            end else if (state_q == ACTIVE && ovf_q && s_axis_tlast) begin
                ovf_d = 1'b0;
                x_d   = '0;
                y_d   = y_q + YW'(1);
                sel_d = lb_next(sel_q);
                if (y_q == Y_LAST) begin
                    state_d = WAIT_SOF;
                    y_d     = '0;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= WAIT_SOF;
            x_q     <= '0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ovf_q   <= ovf_d;
            sel_q   <= sel_d;
        end
    end

    // Rotating line buffers: only the oldest row's RAM is overwritten per line
    for (genvar i = 0; i < LB_N; i++) begin : g_lb
        bicubic_line_ram #(
            .WIDTH (PIX_W),
            .DEPTH (IMG_WIDTH)
        ) u_lb (
            .clk_i   (i_clk),
            .en_i    (wr_c),
            .we_i    (wr_c && (sel_q == lb_sel_t'(i))),
            .addr_i  (x_eff),
            .wdata_i (s_axis_tdata),
            .rdata_o (lb_rd[i])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v1_q   <= 1'b0;
            sof1_q <= 1'b0;
            eof1_q <= 1'b0;
            sh1_q  <= 1'b0;
        end else begin
            v1_q   <= emit_c;
            sof1_q <= sof_c;
            eof1_q <= eof_c;
            sh1_q  <= wr_c;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_c) begin
            pix1_q  <= s_axis_tdata;
            rsel1_q <= sel_q;
        end
    end

    // Column rows y-3..y come from the write-target RAM (old data), the next two, then the live pixel
    always_comb begin
        col_c[0] = lb_rd[rsel1_q];
        col_c[1] = lb_rd[lb_next(rsel1_q)];
        col_c[2] = lb_rd[lb_next(lb_next(rsel1_q))];
        col_c[3] = pix1_q;
        win_d    = win_q;
        if (sh1_q) begin
            for (int r = 0; r < WIN_N; r++) begin
                for (int c = 0; c < WIN_N - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][WIN_N-1] = col_c[r];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            win_q   <= '0;
            o_valid <= 1'b0;
            o_sof   <= 1'b0;
            o_eof   <= 1'b0;
        end else begin
            win_q   <= win_d;
            o_valid <= v1_q;
            o_sof   <= v1_q & sof1_q;
            o_eof   <= v1_q & eof1_q;
        end
    end

    // Pixel k = row*4+col lands in byte 15-k of each channel word
    always_comb begin
        o_pixel_data_r = '0;
        o_pixel_data_g = '0;
        o_pixel_data_b = '0;
        for (int r = 0; r < WIN_N; r++) begin
            for (int c = 0; c < WIN_N; c++) begin
                o_pixel_data_r[CH_W*(WIN_BYTES-1-(r*WIN_N+c)) +: CH_W] = win_q[r][c][R_OFF +: CH_W];
                o_pixel_data_g[CH_W*(WIN_BYTES-1-(r*WIN_N+c)) +: CH_W] = win_q[r][c][G_OFF +: CH_W];
                o_pixel_data_b[CH_W*(WIN_BYTES-1-(r*WIN_N+c)) +: CH_W] = win_q[r][c][B_OFF +: CH_W];
            end
        end
    end

`ifdef BICUBIC_PACKER_FRAME_CHECK_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_err_short <= 1'b0;
            o_err_long  <= 1'b0;
            o_err_count <= '0;
        end else begin
            o_err_short <= short_c;
            o_err_long  <= long_c;
            if ((short_c || long_c) && (o_err_count != 16'hFFFF)) begin
                o_err_count <= o_err_count + 16'd1;
            end
        end
    end
`else
    logic unused_err_c;
    assign unused_err_c = short_c ^ long_c;
`endif

endmodule

// File: tb/tb_bicubic_block_packer.sv
// Scenario-table bench for bicubic_block_packer at 8x6 with a window scoreboard.
module tb_bicubic_block_packer;

    localparam int W = 8;
    localparam int H = 6;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic [23:0]  s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tuser;
    logic         s_axis_tlast;
    logic         i_load_ready;
    logic [127:0] o_pixel_data_r, o_pixel_data_g, o_pixel_data_b;
    logic         o_valid, o_sof, o_eof;
`ifdef BICUBIC_PACKER_FRAME_CHECK_EN
    logic         o_err_short, o_err_long;
    logic [15:0]  o_err_count;
`endif

    bicubic_block_packer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tuser   (s_axis_tuser),
        .s_axis_tlast   (s_axis_tlast),
        .i_load_ready   (i_load_ready),
        .o_pixel_data_r (o_pixel_data_r),
        .o_pixel_data_g (o_pixel_data_g),
        .o_pixel_data_b (o_pixel_data_b),
        .o_valid        (o_valid),
        .o_sof          (o_sof),
        .o_eof          (o_eof)
`ifdef BICUBIC_PACKER_FRAME_CHECK_EN
       ,.o_err_short    (o_err_short),
        .o_err_long     (o_err_long),
        .o_err_count    (o_err_count)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [127:0] r, g, b;
        logic         sof, eof;
        int           c;
    } exp_t;

    typedef struct {
        int mode;      // 0 clean, 1 garbage first, 2 short line, 3 long line, 4 reset mid-frame
        bit tog;
        int n_win, n_sof, n_eof, n_short, n_long, err_total;
    } scen_t;

    exp_t sb[$];
    int   total = 0, bad = 0, cyc = 0;
    int   win_cnt = 0, sof_cnt = 0, eof_cnt = 0, short_cnt = 0, long_cnt = 0;
    bit   toggle_en = 0;
    int   tog_n = 0;
    logic [127:0] first_r;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [23:0] pix(input int x, input int y);
        return {8'(y), 8'(x), 8'(8 * y + x)};
    endfunction

    function automatic exp_t exp_win(input int x, input int y, input int c);
        exp_t e;
        logic [23:0] p;
        int k;
        e.r = '0; e.g = '0; e.b = '0;
        for (int rr = 0; rr < 4; rr++) begin
            for (int cc = 0; cc < 4; cc++) begin
                p = pix(x - 3 + cc, y - 3 + rr);
                k = rr * 4 + cc;
                e.r[8*(15-k) +: 8] = p[7:0];
                e.g[8*(15-k) +: 8] = p[15:8];
                e.b[8*(15-k) +: 8] = p[23:16];
            end
        end
        e.sof = (x == 3 && y == 3);
        e.eof = (x == W - 1 && y == H - 1);
        e.c   = c;
        return e;
    endfunction

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (toggle_en) begin
            tog_n++;
            if (tog_n == 3) begin
                tog_n = 0;
                i_load_ready = ~i_load_ready;
            end
        end
    end

    // Output monitor: every window must match the head of the scoreboard
    always @(negedge i_clk) begin
        exp_t e;
        if (o_valid) begin
            win_cnt++;
            if (o_sof) sof_cnt++;
            if (o_eof) eof_cnt++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got o_valid=1 with no window expected (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("win_r", o_pixel_data_r, e.r);
                check("win_g", o_pixel_data_g, e.g);
                check("win_b", o_pixel_data_b, e.b);
                check("win_sof", 128'(o_sof), 128'(e.sof));
                check("win_eof", 128'(o_eof), 128'(e.eof));
                check("latency", 128'(cyc - e.c), 128'(2));
                if (o_sof) check("first_win_r", o_pixel_data_r, first_r);
            end
        end
`ifdef BICUBIC_PACKER_FRAME_CHECK_EN
        if (o_err_short) short_cnt++;
        if (o_err_long) long_cnt++;
`endif
    end

    task automatic send_beat(input logic [23:0] d, input logic u, input logic l, input bit win,
                             input int x, input int y);
        int n = 0;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        #1;
        check("tready_tracks", 128'(s_axis_tready), 128'(i_load_ready));
        while (!s_axis_tready && n < 100) begin
            @(negedge i_clk);
            #1;
            n++;
            check("tready_tracks", 128'(s_axis_tready), 128'(i_load_ready));
        end
        if (!s_axis_tready) begin
            total++;
            bad++;
            $display("FAIL handshake_timeout: got no tready for beat (%0d,%0d)", x, y);
        end else if (win) begin
            sb.push_back(exp_win(x, y, cyc));
        end
        @(negedge i_clk);
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_frame(input int mode);
        int len;
        if (mode == 1) begin
            for (int g = 0; g < 5; g++) begin
                s_axis_tdata  = 24'($urandom);
                s_axis_tuser  = 1'b0;
                s_axis_tlast  = (g == 4);
                s_axis_tvalid = 1'b1;
                #1;
                check("garbage_not_ready", 128'(s_axis_tready), 128'(0));
                @(negedge i_clk);
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
            end
        end
        for (int y = 0; y < H; y++) begin
            len = W;
            if (mode == 3 && y == 1) len = 10;
            if (mode == 2 && y == 2) len = 6;
            for (int x = 0; x < len; x++) begin
                if (mode == 4 && y == 4 && x == 5) begin
                    send_beat(pix(x, y), 1'b0, 1'b0, 1'b0, x, y);
                    return;
                end
                send_beat((x < W) ? pix(x, y) : 24'hABCDEF, (x == 0 && y == 0), (x == len - 1),
                          (mode != 2) && x >= 3 && x < W && y >= 3, x, y);
            end
        end
    endtask

    scen_t tbl[7];

    initial begin : main
        tbl[0] = '{0, 1'b0, 15, 1, 1, 0, 0, 0};
        tbl[1] = '{0, 1'b1, 15, 1, 1, 0, 0, 0};
        tbl[2] = '{1, 1'b0, 15, 1, 1, 0, 0, 0};
        tbl[3] = '{2, 1'b0,  0, 0, 0, 1, 0, 1};
        tbl[4] = '{0, 1'b0, 15, 1, 1, 0, 0, 1};
        tbl[5] = '{3, 1'b1, 15, 1, 1, 0, 1, 2};
        tbl[6] = '{4, 1'b0, 22, 2, 1, 0, 0, 0};
        first_r = 128'h00010203_08090A0B_10111213_18191A1B;

        i_rst = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        i_load_ready  = 1'b1;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        check("rst_valid", 128'(o_valid), 128'(0));
        check("rst_sof", 128'(o_sof), 128'(0));
        check("rst_eof", 128'(o_eof), 128'(0));
        check("rst_data_r", o_pixel_data_r, 128'(0));
        check("rst_data_g", o_pixel_data_g, 128'(0));
        check("rst_data_b", o_pixel_data_b, 128'(0));
        check("rst_tready", 128'(s_axis_tready), 128'(0));
        s_axis_tuser = 1'b1;
        #1;
        check("wait_sof_tuser_ready", 128'(s_axis_tready), 128'(1));
        i_load_ready = 1'b0;
        #1;
        check("load_ready_gates", 128'(s_axis_tready), 128'(0));
        s_axis_tuser = 1'b0;
        i_load_ready = 1'b1;
        @(negedge i_clk);

        for (int i = 0; i < 7; i++) begin
            win_cnt = 0; sof_cnt = 0; eof_cnt = 0; short_cnt = 0; long_cnt = 0;
            tog_n = 0;
            toggle_en = tbl[i].tog;
            send_frame(tbl[i].mode);
            if (tbl[i].mode == 4) begin
                i_rst = 1'b1;
                @(negedge i_clk);
                i_rst = 1'b0;
                #1;
                check("valid_after_rst", 128'(o_valid), 128'(0));
                check("tready_after_rst", 128'(s_axis_tready), 128'(0));
                @(negedge i_clk);
                send_frame(0);
            end
            toggle_en = 1'b0;
            i_load_ready = 1'b1;
            repeat (8) @(negedge i_clk);
            check("scen_windows", 128'(win_cnt), 128'(tbl[i].n_win));
            check("scen_sof", 128'(sof_cnt), 128'(tbl[i].n_sof));
            check("scen_eof", 128'(eof_cnt), 128'(tbl[i].n_eof));
            check("scen_sb_empty", 128'(sb.size()), 128'(0));
`ifdef BICUBIC_PACKER_FRAME_CHECK_EN
            check("scen_err_short", 128'(short_cnt), 128'(tbl[i].n_short));
            check("scen_err_long", 128'(long_cnt), 128'(tbl[i].n_long));
            check("scen_err_count", 128'(o_err_count), 128'(tbl[i].err_total));
`endif
            sb.delete();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
